// File: rtl/timer_pkg.sv
// Shared encodings for the timer array: channel FSM states, CTRL fields and word offsets.
package timer_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CTRL_W = 4;
   localparam int unsigned MODE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_e;

   localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd0;
   localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'd1;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/pending registers, FSM and registered irq.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [1:0]          wr_word,
   input  logic [WORD_W-1:0]   wdata,
   output logic [4*WORD_W-1:0] rd_words,
   output logic                irq
);

   state_e             state_q, state_n;
   logic [CTRL_W-1:0]  ctrl_q, ctrl_n;
   logic [CNT_W-1:0]   preset_q, preset_n;
   logic [CNT_W-1:0]   count_q, count_n;
   logic               pending_q, pending_n;
   logic               irq_n;
   logic               ctrl_wr, preset_wr, en_eff;

   assign ctrl_wr   = wr_en && (wr_word == OFF_CTRL);
   assign preset_wr = wr_en && (wr_word == OFF_PRESET);
   // A CTRL write takes effect on the FSM in the same edge it lands.
   assign en_eff    = ctrl_wr ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         irq       <= 1'b0;
      end else begin
         state_q   <= state_n;
         ctrl_q    <= ctrl_n;
         preset_q  <= preset_n;
         count_q   <= count_n;
         pending_q <= pending_n;
         irq       <= irq_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      ctrl_n    = ctrl_q;
      preset_n  = preset_q;
      count_n   = count_q;
      pending_n = pending_q;
      irq_n     = pending_q & ctrl_q[CTRL_IM];

      if (ctrl_wr) begin
         ctrl_n    = wdata[CTRL_W-1:0];
         pending_n = 1'b0;
      end
      if (preset_wr) begin
         preset_n = wdata[CNT_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (en_eff) state_n = LOAD;
         end
         LOAD: begin
            count_n = preset_q;
            state_n = CNT;
         end
         CNT: begin
            if (!en_eff) begin
               state_n = IDLE;
            end else if (count_q <= CNT_W'(1)) begin
               count_n = '0;
               state_n = INT;
            end else begin
               count_n = count_q - CNT_W'(1);
            end
         end
         INT: begin
            // Set beats a same-edge CTRL clear; a written EN beats the hardware clear.
            pending_n = 1'b1;
            if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
               state_n = LOAD;
            end else begin
               state_n = IDLE;
               if (!ctrl_wr) ctrl_n[CTRL_EN] = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rd_words = '0;
      rd_words[{OFF_CTRL,   5'd0} +: WORD_W] = WORD_W'(ctrl_q);
      rd_words[{OFF_PRESET, 5'd0} +: WORD_W] = WORD_W'(preset_q);
      rd_words[{OFF_COUNT,  5'd0} +: WORD_W] = WORD_W'(count_q);
      rd_words[{OFF_STATUS, 5'd0} +: WORD_W] = WORD_W'({state_q != IDLE, pending_q});
   end

endmodule

// File: rtl/timer_array.sv
// NUM_CH timer channels behind one processor-bus slave: address decode, write fan-out, read mux, irq_any.
module timer_array
   import timer_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7f00,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              hit,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   localparam int unsigned SPAN = 16 * NUM_CH;

   logic [31:0]         off;
   logic [27:0]         ch_field;
   logic [1:0]          sel_word;
   logic                unused_off;
   logic [4*WORD_W-1:0] ch_rd [NUM_CH];

   assign off        = addr - BASE_ADDR;
   assign ch_field   = off[31:4];
   assign sel_word   = off[3:2];
   assign unused_off = ^off[1:0];

   // Widened compare so the window end never wraps.
   assign hit = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                ({1'b0, addr} <  ({1'b0, BASE_ADDR} + 33'(SPAN)));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (we && hit && (ch_field == 28'(g))),
         .wr_word  (sel_word),
         .wdata    (wdata),
         .rd_words (ch_rd[g]),
         .irq      (irq[g])
      );
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (hit && (ch_field == 28'(i))) rdata = ch_rd[i][{sel_word, 5'd0} +: WORD_W];
      end
   end

   assign irq_any = |irq;

endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
- Parametrised replacement for the two hard-wired timer instances and their ad-hoc address decode at the CPU top level.
- Provides NUM_CH independent down-counting timer channels behind one processor-bus slave port (PrA/PrWE/PrWD/PrRD style).
- Each channel supports one-shot, auto-reload and masked-interrupt operation.
- Per-channel IRQ lines and an OR-reduced line feed the CPU HWInt inputs.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- BASE_ADDR, 32'h00007f00, byte address of channel 0 word 0.
- CNT_W, 32, width of the PRESET and COUNT registers (1..32); reads are zero-extended to 32 bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- addr  in  32  bus byte address; addr[1:0] ignored.
- we  in  1  write strobe; effective only when hit=1.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr; 0 when hit=0.
- hit  out  1  combinational; 1 when addr lies in [BASE_ADDR, BASE_ADDR+16*NUM_CH-1].
- irq  out  NUM_CH  per-channel interrupt, registered-level: pending & IM.
- irq_any  out  1  OR of irq.

Behaviour:
- Address map, per channel i: base BASE_ADDR + 16*i.
  - Word 0 CTRL (rw).
  - Word 1 PRESET (rw).
  - Word 2 COUNT (read-only; writes ignored).
  - Word 3 STATUS: bit0 = pending, bit1 = busy (state != IDLE); read-only.
  - Unmapped bits read 0.
- CTRL fields:
  - [0] EN.
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 = reserved, behave as 0 and read back as written.
  - [3] IM, interrupt enable.
  - [31:4] read 0.
- Reset (reset=0, asynchronous): CTRL, PRESET, COUNT, pending = 0; every channel state IDLE; irq = 0; irq_any = 0. Reset mid-count aborts with no IRQ.
- Per-channel FSM, advancing one step per clk:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds.
    - else COUNT <= 1 -> COUNT <= 0, go to INT.
    - else COUNT <= COUNT-1.
  - INT: pending <= 1.
    - MODE=1: -> LOAD, EN stays 1.
    - Otherwise: hardware clears CTRL.EN, -> IDLE.
- Latency: CTRL write with EN=1 at edge t gives IRQ high after edge t+PRESET+3 for PRESET >= 1. The edges are t (IDLE->LOAD), t+1 (load), then PRESET decrement edges, then the INT edge. PRESET = 0 behaves as PRESET = 1.
- Auto-reload period: PRESET+2 cycles between pending-set events.
- pending is sticky; any CTRL write to that channel clears it.
  - If a CTRL write and INT occur on the same edge, set wins; pending = 1 after the edge.
  - The written EN still overrides the hardware clear in that cycle.
- PRESET write during CNT has no effect on the running count; it is used at the next LOAD.
- CTRL write with EN=1 while in CNT does not restart the count.
- Writing EN=0 stops the channel at the next edge and freezes COUNT.
- IM=0 masks irq only; pending still sets and is visible in STATUS.
- Write with hit=0: ignored.
- Reads are side-effect free.
- Channel index = (addr-BASE_ADDR)>>4. Address arithmetic is 32-bit unsigned; no wrap.

Decomposition:
- Package timer_pkg holds:
  - state encoding (IDLE, LOAD, CNT, INT);
  - MODE constants (MODE_ONESHOT, MODE_RELOAD);
  - word offsets (OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2, OFF_STATUS=3);
  - CTRL bit positions.
- Sub-module timer_channel: one channel's registers, FSM and irq, with a local word-select write port and a 4-word read bus. It is instantiated NUM_CH times via generate.
- Top level timer_array contains only decode, write-enable fan-out, read mux and irq_any.

Test Plan:
- Reset check: reset low mid-count with channel 0 in CNT at COUNT=5 -> all outputs 0; state IDLE; COUNT reads 0 after release.
- One-shot: PRESET0=3, CTRL0=0x9 -> irq[0] rises exactly 6 cycles after the write edge; COUNT reads 0; CTRL0 reads 0x8 (EN auto-cleared). A CTRL0 write of 0x8 drops irq[0] on the next edge.
- Auto-reload: NUM_CH=4, channel 2 PRESET=2, CTRL=0xB -> pending set every 4 cycles; irq[2] stays high until cleared by a CTRL write; irq_any=1; other irq bits 0.
- Masking and collision: IM=0 one-shot completes -> irq=0 and STATUS=1. A CTRL write landing on the INT edge -> pending=1 after the edge.
- Decode: addr=BASE_ADDR+16*NUM_CH with we=1 -> hit=0, rdata=0, no register changes. A COUNT write is ignored. A PRESET write during CNT does not alter the current count; the new value is seen on the next reload.
